// File: rtl/train_step_sequencer.sv
// rtl/train_step_sequencer.sv - training-step sequencer: grad reset, load, forward, backward, grad extract
module train_step_sequencer #(
    parameter int TMO_W = 16
) (
    input  logic       ap_clk,
    input  logic       ap_rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] err_stage,
    output logic       fw_start,
    output logic       bw_start,
    output logic       param_start,
    output logic       grad_start,
    output logic       fw_complete,
    output logic       bw_complete,
    output logic       param_complete,
    output logic       grad_complete,
    input  logic       fw_finish,
    input  logic       bw_finish,
    input  logic       param_finish,
    input  logic       grad_finish,
    input  logic       fw_idle,
    input  logic       bw_idle,
    input  logic       param_idle,
    input  logic       grad_idle,
    output logic       grad_reset,
    input  logic       grad_reset_busy,
    output logic       cache_en,
    output logic       bram_sel
);

    typedef enum logic [3:0] {
        S_IDLE, S_GRST, S_GRST_WAIT,
        S_LOAD_RUN, S_LOAD_ACK, S_FW_RUN, S_FW_ACK,
        S_BW_RUN, S_BW_ACK, S_GRAD_RUN, S_GRAD_ACK, S_DONE
    } state_t;

    localparam logic [TMO_W-1:0] WD_MAX = {TMO_W{1'b1}};
    localparam logic [TMO_W-1:0] WD_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [TMO_W-1:0] wd_q, wd_d;
    logic [3:0]       start_q, start_d;
    logic [3:0]       complete_q, complete_d;
    logic             grad_reset_q, grad_reset_d;
    logic             cache_en_q, cache_en_d;
    logic             bram_sel_q, bram_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [2:0]       err_stage_q, err_stage_d;
    logic             cmd_ready_q, cmd_ready_d;

    // Stage index: 0 load, 1 forward, 2 backward, 3 grad extract.
    logic [3:0]       finish_v, idle_v;
    logic             in_run, in_ack;
    logic [1:0]       cur_idx;
    logic [TMO_W-1:0] wd_inc;
    logic             wd_tmo;

    assign finish_v = {grad_finish, bw_finish, fw_finish, param_finish};
    assign idle_v   = {grad_idle, bw_idle, fw_idle, param_idle};

    function automatic state_t first_stage(input logic [2:0] op, input logic [2:0] from);
        state_t s;
        s = S_DONE;
        if (from <= 3'd3 && op[2]) s = S_GRAD_RUN;
        if (from <= 3'd2 && op[1]) s = S_BW_RUN;
        if (from <= 3'd1)          s = S_FW_RUN;
        if (from == 3'd0 && op[0]) s = S_LOAD_RUN;
        return s;
    endfunction

    function automatic state_t ack_of(input logic [1:0] idx);
        state_t s;
        case (idx)
            2'd0:    s = S_LOAD_ACK;
            2'd1:    s = S_FW_ACK;
            2'd2:    s = S_BW_ACK;
            default: s = S_GRAD_ACK;
        endcase
        return s;
    endfunction

    always_comb begin
        in_run  = 1'b0;
        in_ack  = 1'b0;
        cur_idx = 2'd0;
        case (state_q)
            S_LOAD_RUN: begin in_run = 1'b1; cur_idx = 2'd0; end
            S_LOAD_ACK: begin in_ack = 1'b1; cur_idx = 2'd0; end
            S_FW_RUN:   begin in_run = 1'b1; cur_idx = 2'd1; end
            S_FW_ACK:   begin in_ack = 1'b1; cur_idx = 2'd1; end
            S_BW_RUN:   begin in_run = 1'b1; cur_idx = 2'd2; end
            S_BW_ACK:   begin in_ack = 1'b1; cur_idx = 2'd2; end
            S_GRAD_RUN: begin in_run = 1'b1; cur_idx = 2'd3; end
            S_GRAD_ACK: begin in_ack = 1'b1; cur_idx = 2'd3; end
            default: ;
        endcase
        wd_inc = (wd_q == WD_MAX) ? WD_MAX : wd_q + WD_ONE;
        wd_tmo = (wd_inc == WD_MAX);
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wd_d        = wd_q;
        err_d       = err_q;
        err_stage_d = err_stage_q;
        case (state_q)
            S_IDLE: begin
                wd_d = '0;
                if (cmd_valid && cmd_ready_q) begin
                    op_d        = cmd_op;
                    err_d       = 1'b0;
                    err_stage_d = 3'd0;
                    state_d     = cmd_op[1] ? S_GRST : first_stage(cmd_op, 3'd0);
                end
            end
            S_GRST: begin
                wd_d    = '0;
                state_d = S_GRST_WAIT;
            end
            S_GRST_WAIT: begin
                if (!grad_reset_busy) begin
                    wd_d    = '0;
                    state_d = first_stage(op_q, 3'd0);
                end else if (wd_tmo) begin
                    wd_d        = '0;
                    state_d     = S_IDLE;
                    err_d       = 1'b1;
                    err_stage_d = 3'd1;
                end else begin
                    wd_d = wd_inc;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                // A finish seen on the timeout edge still completes the stage normally.
                if (in_run) begin
                    if (start_q[cur_idx] && finish_v[cur_idx]) begin
                        wd_d    = '0;
                        state_d = ack_of(cur_idx);
                    end else if (wd_tmo) begin
                        wd_d        = '0;
                        state_d     = S_IDLE;
                        err_d       = 1'b1;
                        err_stage_d = {1'b0, cur_idx} + 3'd2;
                    end else begin
                        wd_d = wd_inc;
                    end
                end else if (in_ack) begin
                    wd_d    = '0;
                    state_d = first_stage(op_q, {1'b0, cur_idx} + 3'd1);
                end
            end
        endcase
    end

    // Outputs are registered from the next state; a stage's start holds once raised, gated only on entry by idle.
    always_comb begin
        start_d      = 4'b0000;
        complete_d   = 4'b0000;
        case (state_d)
            S_LOAD_RUN: start_d[0]    = start_q[0] | idle_v[0];
            S_FW_RUN:   start_d[1]    = start_q[1] | idle_v[1];
            S_BW_RUN:   start_d[2]    = start_q[2] | idle_v[2];
            S_GRAD_RUN: start_d[3]    = start_q[3] | idle_v[3];
            S_LOAD_ACK: complete_d[0] = 1'b1;
            S_FW_ACK:   complete_d[1] = 1'b1;
            S_BW_ACK:   complete_d[2] = 1'b1;
            S_GRAD_ACK: complete_d[3] = 1'b1;
            default: ;
        endcase
        grad_reset_d = (state_d == S_GRST);
        cache_en_d   = ((state_d == S_FW_RUN) || (state_d == S_FW_ACK)) && op_d[1];
        bram_sel_d   = (state_d == S_GRAD_RUN) || (state_d == S_GRAD_ACK);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        cmd_ready_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= 3'd0;
            wd_q         <= '0;
            start_q      <= 4'b0000;
            complete_q   <= 4'b0000;
            grad_reset_q <= 1'b0;
            cache_en_q   <= 1'b0;
            bram_sel_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_stage_q  <= 3'd0;
            cmd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            wd_q         <= wd_d;
            start_q      <= start_d;
            complete_q   <= complete_d;
            grad_reset_q <= grad_reset_d;
            cache_en_q   <= cache_en_d;
            bram_sel_q   <= bram_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_stage_q  <= err_stage_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign err_stage      = err_stage_q;
    assign param_start    = start_q[0];
    assign fw_start       = start_q[1];
    assign bw_start       = start_q[2];
    assign grad_start     = start_q[3];
    assign param_complete = complete_q[0];
    assign fw_complete    = complete_q[1];
    assign bw_complete    = complete_q[2];
    assign grad_complete  = complete_q[3];
    assign grad_reset     = grad_reset_q;
    assign cache_en       = cache_en_q;
    assign bram_sel       = bram_sel_q;

endmodule

// File: tb/tb_train_step_sequencer.sv
// tb/tb_train_step_sequencer.sv - randomized self-checking bench for train_step_sequencer
module tb_train_step_sequencer;
    localparam int TMO_W = 4;
    localparam int WD_LIMIT = 2**TMO_W - 1;

    logic       ap_clk = 1'b0;
    logic       ap_rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic       cmd_ready, busy, done, err;
    logic [2:0] err_stage;
    logic       fw_start, bw_start, param_start, grad_start;
    logic       fw_complete, bw_complete, param_complete, grad_complete;
    logic       fw_finish = 1'b0, bw_finish = 1'b0, param_finish = 1'b0, grad_finish = 1'b0;
    logic       fw_idle = 1'b1, bw_idle = 1'b1, param_idle = 1'b1, grad_idle = 1'b1;
    logic       grad_reset, grad_reset_busy = 1'b0, cache_en, bram_sel;

    int n_checks = 0;
    int n_fail = 0;
    int fin_dly[4];
    int gbusy;

    logic [3:0]  start_v, complete_v;
    logic [17:0] out_vec;
    assign start_v    = {grad_start, bw_start, fw_start, param_start};
    assign complete_v = {grad_complete, bw_complete, fw_complete, param_complete};
    assign out_vec    = {start_v, complete_v, grad_reset, cache_en, bram_sel, busy, done, err, err_stage, cmd_ready};

    train_step_sequencer #(.TMO_W(TMO_W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .busy(busy), .done(done), .err(err), .err_stage(err_stage),
        .fw_start(fw_start), .bw_start(bw_start), .param_start(param_start), .grad_start(grad_start),
        .fw_complete(fw_complete), .bw_complete(bw_complete),
        .param_complete(param_complete), .grad_complete(grad_complete),
        .fw_finish(fw_finish), .bw_finish(bw_finish), .param_finish(param_finish), .grad_finish(grad_finish),
        .fw_idle(fw_idle), .bw_idle(bw_idle), .param_idle(param_idle), .grad_idle(grad_idle),
        .grad_reset(grad_reset), .grad_reset_busy(grad_reset_busy),
        .cache_en(cache_en), .bram_sel(bram_sel)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(negedge ap_clk);
    endtask

    task automatic drive_finish(input logic [3:0] fv);
        param_finish = fv[0];
        fw_finish    = fv[1];
        bw_finish    = fv[2];
        grad_finish  = fv[3];
    endtask

    // Event codes: 1 grad_reset, 2..5 stage complete (load, fw, bw, grad), 6 done.
    task automatic run_cmd(input logic [2:0] op, input int idle_lo, input bit rst_bw);
        int   exp_q[$];
        int   ev_q[$];
        int   exp_hi[4];
        int   hi[4];
        bit   prev_idle[4];
        int   exp_err, exp_first, first_k, grst_k, k;
        bit   halted, aborted, en;
        logic [3:0] fv;

        exp_err = 0;
        halted  = 0;
        for (int s = 0; s < 4; s++) begin exp_hi[s] = 0; hi[s] = 0; end
        if (op[1]) begin
            exp_q.push_back(1);
            if (gbusy >= WD_LIMIT) begin exp_err = 1; halted = 1; end
        end
        for (int s = 0; s < 4; s++) begin
            en = (s == 1) || (s == 0 && op[0]) || (s == 2 && op[1]) || (s == 3 && op[2]);
            if (!halted && en) begin
                if (rst_bw && s == 2) begin
                    exp_hi[2] = 3; halted = 1;
                end else if (fin_dly[s] == 0) begin
                    exp_hi[s] = WD_LIMIT; exp_err = s + 2; halted = 1;
                end else begin
                    exp_hi[s] = fin_dly[s]; exp_q.push_back(s + 2);
                end
            end
        end
        if (!halted) exp_q.push_back(6);
        if (op[1])      exp_first = (gbusy >= WD_LIMIT) ? -1 : gbusy + 3;
        else if (op[0]) exp_first = 1;
        else            exp_first = (idle_lo > 0) ? idle_lo + 1 : 1;

        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_before_accept: got %b expected 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        drive_finish(4'b0000);
        grad_reset_busy = 1'b0;
        fw_idle = (idle_lo == 0);
        prev_idle[0] = 1; prev_idle[1] = fw_idle; prev_idle[2] = 1; prev_idle[3] = 1;
        first_k = -1; grst_k = -1; aborted = 0;

        for (k = 1; k <= 400; k++) begin
            tick();
            cmd_valid = 1'b0;
            drive_finish(4'b0000);
            if (k == 1) begin
                n_checks++;
                if (err !== 1'b0 || err_stage !== 3'd0 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL accept_state: got err=%b stage=%0d busy=%b expected 0 0 1", err, err_stage, busy);
                end
            end
            n_checks++;
            if ($countones(start_v) > 1 || ($countones(complete_v) + int'(grad_reset)) > 1) begin
                n_fail++; $display("FAIL onehot k=%0d: got start=%b complete=%b grst=%b expected at most one", k, start_v, complete_v, grad_reset);
            end
            if (grad_reset) begin ev_q.push_back(1); if (grst_k < 0) grst_k = k; end
            for (int s = 0; s < 4; s++) if (complete_v[s]) ev_q.push_back(s + 2);
            if (done) ev_q.push_back(6);
            for (int s = 0; s < 4; s++) begin
                if (start_v[s]) begin
                    if (hi[s] == 0) begin
                        if (first_k < 0) first_k = k;
                        n_checks++;
                        if (prev_idle[s] !== 1'b1) begin
                            n_fail++; $display("FAIL start_needs_idle s=%0d: got idle %b expected 1", s, prev_idle[s]);
                        end
                    end
                    hi[s]++;
                end
            end
            if (fw_start || fw_complete) begin
                n_checks++;
                if (cache_en !== op[1]) begin n_fail++; $display("FAIL cache_en_fw: got %b expected %b", cache_en, op[1]); end
            end else if ((|start_v) || (|complete_v) || grad_reset || done) begin
                n_checks++;
                if (cache_en !== 1'b0) begin n_fail++; $display("FAIL cache_en_other: got %b expected 0", cache_en); end
            end
            if (grad_start || grad_complete) begin
                n_checks++;
                if (bram_sel !== 1'b1) begin n_fail++; $display("FAIL bram_sel_grad: got %b expected 1", bram_sel); end
            end else if ((|start_v) || (|complete_v) || grad_reset || done) begin
                n_checks++;
                if (bram_sel !== 1'b0) begin n_fail++; $display("FAIL bram_sel_other: got %b expected 0", bram_sel); end
            end
            if (!busy) break;
            if (rst_bw && bw_start && hi[2] == 3) begin
                ap_rst_n = 1'b0;
                tick();
                n_checks++;
                if (out_vec !== 18'd1) begin
                    n_fail++; $display("FAIL reset_mid_bw: got %h expected %h", out_vec, 18'd1);
                end
                ap_rst_n = 1'b1;
                aborted = 1;
                break;
            end
            cmd_valid = cmd_ready ? 1'b0 : 1'($urandom % 2);
            cmd_op    = 3'($urandom);
            for (int s = 0; s < 4; s++) fv[s] = start_v[s] && (hi[s] == fin_dly[s]);
            drive_finish(fv);
            grad_reset_busy = (grst_k > 0) && (k >= grst_k + 1) && (k <= grst_k + gbusy);
            fw_idle = (k >= idle_lo);
            prev_idle[1] = fw_idle;
        end
        drive_finish(4'b0000);
        grad_reset_busy = 1'b0;
        fw_idle = 1'b1;

        if (k > 400) begin
            n_checks++; n_fail++; $display("FAIL cycle_bound: got %0d cycles expected return to idle", k);
        end
        if (!aborted) begin
            n_checks++;
            if (cmd_ready !== 1'b1 || err !== (exp_err != 0) || int'(err_stage) != exp_err) begin
                n_fail++; $display("FAIL end_status: got ready=%b err=%b stage=%0d expected 1 %0d %0d", cmd_ready, err, err_stage, exp_err != 0, exp_err);
            end
        end
        for (int s = 0; s < 4; s++) begin
            n_checks++;
            if (hi[s] != exp_hi[s]) begin n_fail++; $display("FAIL start_len s=%0d: got %0d expected %0d", s, hi[s], exp_hi[s]); end
        end
        n_checks++;
        if (first_k != exp_first) begin n_fail++; $display("FAIL first_start: got %0d expected %0d", first_k, exp_first); end
        n_checks++;
        if (ev_q.size() != exp_q.size()) begin n_fail++; $display("FAIL trace_len: got %0d expected %0d", ev_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            if (i < ev_q.size()) begin
                n_checks++;
                if (ev_q[i] != exp_q[i]) begin n_fail++; $display("FAIL trace[%0d]: got %0d expected %0d", i, ev_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic set_fin(input int l, input int f, input int b, input int g);
        fin_dly[0] = l; fin_dly[1] = f; fin_dly[2] = b; fin_dly[3] = g;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (out_vec !== 18'd1) begin n_fail++; $display("FAIL reset_values: got %h expected %h", out_vec, 18'd1); end
        ap_rst_n = 1'b1;
        tick();
        n_checks++;
        if (out_vec !== 18'd1) begin n_fail++; $display("FAIL post_release: got %h expected %h", out_vec, 18'd1); end
    endtask

    task automatic test_fw_only();
        set_fin(5, 3, 5, 5); gbusy = 0;
        run_cmd(3'b000, 0, 0);
    endtask

    task automatic test_full();
        set_fin(2, 4, 6, 1); gbusy = 4;
        run_cmd(3'b111, 0, 0);
    endtask

    task automatic test_timeout();
        set_fin(1, 2, 0, 1); gbusy = 2;
        run_cmd(3'b010, 0, 0);
        set_fin(1, 1, 1, 1); gbusy = 0;
        run_cmd(3'b000, 0, 0);
    endtask

    task automatic test_reset_mid();
        set_fin(1, 2, 0, 1); gbusy = 1;
        run_cmd(3'b010, 0, 1);
    endtask

    task automatic test_idle_hold();
        set_fin(1, 3, 1, 1); gbusy = 0;
        run_cmd(3'b000, 5, 0);
    endtask

    task automatic test_finish_edges();
        set_fin(1, 1, 15, 15); gbusy = 14;
        run_cmd(3'b110, 0, 0);
        gbusy = 15;
        run_cmd(3'b011, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 30; it++) begin
            for (int s = 0; s < 4; s++) fin_dly[s] = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 15);
            gbusy = ($urandom % 8 == 0) ? $urandom_range(15, 17) : $urandom_range(0, 14);
            run_cmd(3'($urandom_range(0, 7)), 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_fw_only();
        test_full();
        test_timeout();
        test_reset_mid();
        test_idle_hold();
        test_finish_edges();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/train_step_sequencer.md
TRAIN_STEP_SEQUENCER -- requirements
Module: train_step_sequencer

Interface
REQ-001 Parameter TMO_W, default 16, width of per-stage watchdog counter; timeout fires at count 2^TMO_W-1.
REQ-002 ap_clk  in  1  single clock; all state updates on rising edge.
REQ-003 ap_rst_n  in  1  reset, synchronous, active-low.
REQ-004 cmd_valid  in  1  command request; cmd_ready  out  1  sequencer can accept.
REQ-005 cmd_op  in  3  bit0 load_param, bit1 do_backward, bit2 extract_grad; sampled only on accept.
REQ-006 busy  out  1  high from accept until return to IDLE; done  out  1  one-cycle end-of-step pulse; err  out  1  sticky timeout flag.
REQ-007 err_stage  out  3  stage code at timeout: 1 GRST, 2 LOAD, 3 FW, 4 BW, 5 GRAD.
REQ-008 {fw,bw,param,grad}_start  out  1 each; {fw,bw,param,grad}_complete  out  1 each.
REQ-009 {fw,bw,param,grad}_finish  in  1 each; {fw,bw,param,grad}_idle  in  1 each.
REQ-010 grad_reset  out  1; grad_reset_busy  in  1; cache_en  out  1; bram_sel  out  1.

Function
REQ-011 States: IDLE, GRST, GRST_WAIT, then per stage S in {LOAD, FW, BW, GRAD} a pair S_RUN and S_ACK, then DONE.
REQ-012 Accept = cmd_valid & cmd_ready; cmd_ready = 1 only in IDLE; cmd_op latched on accept; accept clears err and err_stage to 0.
REQ-013 From IDLE on accept: to GRST if do_backward, else LOAD_RUN if load_param, else FW_RUN.
REQ-014 GRST: grad_reset = 1 for exactly one cycle, then GRST_WAIT; leave GRST_WAIT on first cycle grad_reset_busy = 0, sampled no earlier than the cycle after the pulse.
REQ-015 After GRST_WAIT: LOAD_RUN if load_param else FW_RUN.
REQ-016 S_RUN: matching *_start held 1 every cycle until matching *_finish sampled 1; on that edge start drops and state goes to S_ACK.
REQ-017 S_ACK: matching *_complete = 1 for exactly one cycle; state advances next edge.
REQ-018 Stage order: LOAD (if load_param) -> FW (always) -> BW (if do_backward) -> GRAD (if extract_grad) -> DONE; disabled stages skipped with zero cycles.
REQ-019 Stage entry requires matching *_idle = 1; while 0 in S_RUN, start held 0, watchdog still counts.
REQ-020 finish = 1 on the first S_RUN cycle is legal; start is still 1 for that cycle (min S_RUN length 1).
REQ-021 DONE: done = 1 one cycle, then IDLE; busy = 0 in IDLE only.
REQ-022 cache_en = 1 throughout FW_RUN/FW_ACK when do_backward = 1, else 0.
REQ-023 bram_sel = 1 throughout GRAD_RUN/GRAD_ACK, else 0.
REQ-024 Watchdog: cleared on entry to each GRST_WAIT/S_RUN; +1 per cycle waiting; saturating, no wrap.
REQ-025 Watchdog reaching 2^TMO_W-1: all start outputs drop that edge, err = 1, err_stage = stage code, state -> IDLE; no complete, no done pulse.
REQ-026 finish and timeout on same edge: finish wins, normal S_ACK path.
REQ-027 At most one *_start, one *_complete, grad_reset asserted per cycle; all outputs registered.
REQ-028 cmd_valid outside IDLE ignored, never queued.

Reset
REQ-029 ap_rst_n = 0 at an edge forces IDLE from any state, incl. mid-stage, no complete or done issued.
REQ-030 Reset values: every *_start, *_complete, grad_reset, cache_en, bram_sel, busy, done, err = 0; err_stage = 0; watchdog = 0; cmd_ready = 1 first cycle after release.

Verification
REQ-031 cmd_op=3'b000, fw_idle=1, fw_finish 3 cycles after fw_start rises -> fw_start high 3 cycles, fw_complete 1 cycle, done 1 cycle, cache_en=0 throughout.
REQ-032 cmd_op=3'b111, all idle=1, grad_reset_busy high 4 cycles -> order grad_reset, param, fw (cache_en=1), bw, grad (bram_sel=1), done; exactly one complete per stage.
REQ-033 TMO_W=4, cmd_op=3'b010, bw_finish never rises -> bw_start drops after 15 wait cycles, err=1, err_stage=4, no done; next accept clears err.
REQ-034 ap_rst_n=0 during BW_RUN -> next cycle all outputs at reset values, cmd_ready=1, no bw_complete.
REQ-035 fw_idle=0 for 5 cycles after accept, cmd_op=3'b000 -> fw_start 0 for those 5 cycles, then 1; cmd_valid pulses while busy not accepted.
REQ-036 fw_finish=1 on first FW_RUN cycle; TMO_W=4 with finish on 15th wait cycle -> S_ACK taken, err stays 0.
